// File: rtl/plot_sink_framebuffer_if.sv
// Pixel-plot write bus plus framebuffer read-back and status signals.
// master = drawing FSM / consumer side, slave = the framebuffer sink.
interface plot_sink_framebuffer_if #(
    parameter int COLOUR_BITS = 3
);
    logic [7:0]             iX;
    logic [6:0]             iY;
    logic [COLOUR_BITS-1:0] iColour;
    logic                   iPlot;
    logic                   iClear;
    logic                   iRdEn;
    logic [14:0]            iRdAddr;
    logic [COLOUR_BITS-1:0] oRdColour;
    logic                   oRdValid;
    logic                   oBusy;
    logic                   oFrameDone;
    logic                   oRangeErr;
    logic                   oDropErr;
    logic [14:0]            oPixelCount;

    modport master (
        output iX, iY, iColour, iPlot, iClear, iRdEn, iRdAddr,
        input  oRdColour, oRdValid, oBusy, oFrameDone, oRangeErr, oDropErr, oPixelCount
    );

    modport slave (
        input  iX, iY, iColour, iPlot, iClear, iRdEn, iRdAddr,
        output oRdColour, oRdValid, oBusy, oFrameDone, oRangeErr, oDropErr, oPixelCount
    );
endinterface

// File: rtl/plot_sink_framebuffer.sv
// 160x120 framebuffer sink for the x/y/colour/plot bus: stores pixels, validates
// range and raster order, flags complete frames, and offers a registered read port.
module plot_sink_framebuffer #(
    parameter int                     X_PIXELS     = 160,
    parameter int                     Y_PIXELS     = 120,
    parameter int                     COLOUR_BITS  = 3,
    parameter logic [COLOUR_BITS-1:0] CLEAR_COLOUR = '0
) (
    input  logic                   Clock,
    input  logic                   Reset,
    plot_sink_framebuffer_if.slave bus
);
    localparam int          NUM_CELLS = X_PIXELS * Y_PIXELS;
    localparam logic [14:0] LAST_ADDR = 15'(NUM_CELLS - 1);
    localparam logic [7:0]  X_LIM     = 8'(X_PIXELS);
    localparam logic [6:0]  Y_LIM     = 7'(Y_PIXELS);

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e                 state_q, state_d;
    logic [14:0]            clr_addr_q, clr_addr_d;
    logic [14:0]            run_len_q, run_len_d;
    logic [14:0]            last_addr_q, last_addr_d;
    logic                   frame_done_q, frame_done_d;
    logic                   range_err_q, range_err_d;
    logic                   drop_err_q, drop_err_d;
    logic [COLOUR_BITS-1:0] rd_colour_q, rd_colour_d;
    logic                   rd_valid_q, rd_valid_d;

    logic [COLOUR_BITS-1:0] fb_mem [0:NUM_CELLS-1];
    logic                   mem_we;
    logic [14:0]            mem_waddr;
    logic [COLOUR_BITS-1:0] mem_wdata;

    logic [14:0] wa;
    logic        plot_ok;

    // y*160 as shift-and-add so no multiplier is needed
    assign wa      = 15'({bus.iY, 7'b0}) + 15'({bus.iY, 5'b0}) + 15'(bus.iX);
    assign plot_ok = (bus.iX < X_LIM) && (bus.iY < Y_LIM);

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        run_len_d    = run_len_q;
        last_addr_d  = last_addr_q;
        frame_done_d = 1'b0;
        range_err_d  = 1'b0;
        drop_err_d   = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = wa;
        mem_wdata    = bus.iColour;
        rd_valid_d   = bus.iRdEn;
        rd_colour_d  = rd_colour_q;

        // Old memory contents are read here, so a same-cycle write is not visible.
        if (bus.iRdEn) begin
            rd_colour_d = (bus.iRdAddr <= LAST_ADDR) ? fb_mem[bus.iRdAddr] : '0;
        end

        // Completed frame shows its full count for one cycle, then the run restarts.
        if (frame_done_q) begin
            run_len_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.iPlot) begin
                    if (plot_ok) begin
                        mem_we      = 1'b1;
                        last_addr_d = wa;
                        if (wa == '0) begin
                            run_len_d = 15'd1;
                        end else if ((wa == last_addr_q + 15'd1) && (run_len_q != '0)) begin
                            run_len_d = run_len_q + 15'd1;
                        end else begin
                            run_len_d = '0;
                        end
                        frame_done_d = (wa == LAST_ADDR) && (run_len_q == LAST_ADDR);
                    end else begin
                        range_err_d = 1'b1;
                        run_len_d   = '0;
                    end
                end
                if (bus.iClear) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                mem_we     = 1'b1;
                mem_waddr  = clr_addr_q;
                mem_wdata  = CLEAR_COLOUR;
                drop_err_d = bus.iPlot;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = IDLE;
                    clr_addr_d = '0;
                    run_len_d  = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 15'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= IDLE;
            clr_addr_q   <= '0;
            run_len_q    <= '0;
            last_addr_q  <= '0;
            frame_done_q <= 1'b0;
            range_err_q  <= 1'b0;
            drop_err_q   <= 1'b0;
            rd_colour_q  <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            run_len_q    <= run_len_d;
            last_addr_q  <= last_addr_d;
            frame_done_q <= frame_done_d;
            range_err_q  <= range_err_d;
            drop_err_q   <= drop_err_d;
            rd_colour_q  <= rd_colour_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    // Contents survive reset; a reset mid-clear leaves the buffer partly cleared.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            fb_mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.oRdColour   = rd_colour_q;
    assign bus.oRdValid    = rd_valid_q;
    assign bus.oBusy       = (state_q == CLEAR);
    assign bus.oFrameDone  = frame_done_q;
    assign bus.oRangeErr   = range_err_q;
    assign bus.oDropErr    = drop_err_q;
    assign bus.oPixelCount = run_len_q;
endmodule
